hazard_ctrl: RTL and testbench

//  Drives the stop/flush inputs of the pipeline registers (IF_ID, ID_EX, EX_MEM) and the PC stop.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stop/flush control for load-use hazards, taken branches
// and data-memory freezes, with saturating stall/flush performance counters.
// Ports:
//   clk, rst (async, active-low)
//   ID_useful, ID_rR1, ID_rR2, ID_rr1, ID_rr2 : ID-stage operand fields
//   EX_useful, EX_wR, EX_regWEn, EX_wbSel     : EX-stage writeback fields
//   br_taken, mem_busy, cnt_clr               : branch resolve, memory freeze, counter clear
//   pc_stop, if_id_stop, id_ex_stop, ex_mem_stop : hold controls (combinational)
//   if_id_flush, id_ex_flush                  : active-low bubble inserts (combinational)
//   stall_cnt, flush_cnt                      : saturating event counters (registered)
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned BR_KILL_CYC = 1,
  parameter int unsigned CNT_W       = 32,
  parameter logic [1:0]  WB_MEM      = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_useful,
  input  logic [4:0]       ID_rR1,
  input  logic [4:0]       ID_rR2,
  input  logic             ID_rr1,
  input  logic             ID_rr2,
  input  logic             EX_useful,
  input  logic [4:0]       EX_wR,
  input  logic             EX_regWEn,
  input  logic [1:0]       EX_wbSel,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             if_id_flush,
  output logic             id_ex_stop,
  output logic             id_ex_flush,
  output logic             ex_mem_stop,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned MAX_CYC = (LOAD_LAT > BR_KILL_CYC) ? LOAD_LAT : BR_KILL_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {RUN, LU_STALL, BR_KILL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lu_c;
  logic          stall_inc, flush_inc;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu_c = ID_useful && EX_useful && EX_regWEn && (EX_wbSel == WB_MEM) &&
           (EX_wR != 5'd0) &&
           ((ID_rr1 && (ID_rR1 == EX_wR)) || (ID_rr2 && (ID_rR2 == EX_wR)));
  end

  // State and countdown register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and pipeline controls; reset forces the default controls.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_stop     = 1'b0;
    if_id_stop  = 1'b0;
    if_id_flush = 1'b1;
    id_ex_stop  = 1'b0;
    id_ex_flush = 1'b1;
    ex_mem_stop = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        // Freeze everything; branch and hazard are re-evaluated once memory is ready.
        pc_stop     = 1'b1;
        if_id_stop  = 1'b1;
        id_ex_stop  = 1'b1;
        ex_mem_stop = 1'b1;
      end else if (br_taken) begin
        // A taken branch wins in every state, including restarting an ongoing kill.
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        flush_inc   = 1'b1;
        if (BR_KILL_CYC > 1) begin
          state_nxt = BR_KILL;
          cnt_nxt   = CW'(BR_KILL_CYC - 1);
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (lu_c) begin
              pc_stop     = 1'b1;
              if_id_stop  = 1'b1;
              id_ex_flush = 1'b0;
              stall_inc   = 1'b1;
              if (LOAD_LAT > 1) begin
                state_nxt = LU_STALL;
                cnt_nxt   = CW'(LOAD_LAT - 1);
              end
            end
          end
          LU_STALL: begin
            pc_stop     = 1'b1;
            if_id_stop  = 1'b1;
            id_ex_flush = 1'b0;
            stall_inc   = 1'b1;
            cnt_nxt     = cnt - CW'(1);
            if (cnt == CW'(1)) state_nxt = RUN;
          end
          BR_KILL: begin
            // PC runs so the branch target fetch proceeds; wrong-path fetches are dropped.
            if_id_flush = 1'b0;
            cnt_nxt     = cnt - CW'(1);
            if (cnt == CW'(1)) state_nxt = RUN;
          end
          default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Saturating counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with different parameters
// share one stimulus; each scenario checks the instance it targets.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ID_useful, ID_rr1, ID_rr2, EX_useful, EX_regWEn, br_taken, mem_busy, cnt_clr;
  logic [4:0] ID_rR1, ID_rR2, EX_wR;
  logic [1:0] EX_wbSel;

  // Control vectors packed as {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop}
  logic [5:0] oa, ob, oc;
  logic [3:0]  sa, fa;
  logic [31:0] sb, fb;
  logic [7:0]  sc, fc;

  localparam logic [5:0] DEF   = 6'b001010;
  localparam logic [5:0] STALL = 6'b111000;
  localparam logic [5:0] BUSY  = 6'b111111;
  localparam logic [5:0] BR0   = 6'b000000;
  localparam logic [5:0] KILL  = 6'b000010;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .BR_KILL_CYC(3), .CNT_W(4), .WB_MEM(2'b01)) u_a (
    .clk(clk), .rst(rst), .ID_useful(ID_useful), .ID_rR1(ID_rR1), .ID_rR2(ID_rR2),
    .ID_rr1(ID_rr1), .ID_rr2(ID_rr2), .EX_useful(EX_useful), .EX_wR(EX_wR),
    .EX_regWEn(EX_regWEn), .EX_wbSel(EX_wbSel), .br_taken(br_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_stop(oa[5]), .if_id_stop(oa[4]), .if_id_flush(oa[3]),
    .id_ex_stop(oa[2]), .id_ex_flush(oa[1]), .ex_mem_stop(oa[0]),
    .stall_cnt(sa), .flush_cnt(fa));

  hazard_ctrl #(.LOAD_LAT(3), .BR_KILL_CYC(1), .CNT_W(32), .WB_MEM(2'b01)) u_b (
    .clk(clk), .rst(rst), .ID_useful(ID_useful), .ID_rR1(ID_rR1), .ID_rR2(ID_rR2),
    .ID_rr1(ID_rr1), .ID_rr2(ID_rr2), .EX_useful(EX_useful), .EX_wR(EX_wR),
    .EX_regWEn(EX_regWEn), .EX_wbSel(EX_wbSel), .br_taken(br_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_stop(ob[5]), .if_id_stop(ob[4]), .if_id_flush(ob[3]),
    .id_ex_stop(ob[2]), .id_ex_flush(ob[1]), .ex_mem_stop(ob[0]),
    .stall_cnt(sb), .flush_cnt(fb));

  hazard_ctrl #(.LOAD_LAT(4), .BR_KILL_CYC(2), .CNT_W(8), .WB_MEM(2'b01)) u_c (
    .clk(clk), .rst(rst), .ID_useful(ID_useful), .ID_rR1(ID_rR1), .ID_rR2(ID_rR2),
    .ID_rr1(ID_rr1), .ID_rr2(ID_rr2), .EX_useful(EX_useful), .EX_wR(EX_wR),
    .EX_regWEn(EX_regWEn), .EX_wbSel(EX_wbSel), .br_taken(br_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_stop(oc[5]), .if_id_stop(oc[4]), .if_id_flush(oc[3]),
    .id_ex_stop(oc[2]), .id_ex_flush(oc[1]), .ex_mem_stop(oc[0]),
    .stall_cnt(sc), .flush_cnt(fc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_useful = 1'b0; ID_rR1 = 5'd0; ID_rR2 = 5'd0; ID_rr1 = 1'b0; ID_rr2 = 1'b0;
    EX_useful = 1'b0; EX_wR = 5'd0; EX_regWEn = 1'b0; EX_wbSel = 2'b00;
    br_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // EX load to r5, ID reads r5 through rR1.
  task automatic load_hz();
    idle();
    ID_useful = 1'b1; ID_rR1 = 5'd5; ID_rr1 = 1'b1;
    EX_useful = 1'b1; EX_wR = 5'd5; EX_regWEn = 1'b1; EX_wbSel = 2'b01;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    // Reset: defaults even with a live hazard and branch on the inputs.
    rst = 1'b0;
    load_hz();
    br_taken = 1'b1;
    #2;
    chk("rst_ctrl_a", 32'(oa), 32'(DEF));
    chk("rst_ctrl_b", 32'(ob), 32'(DEF));
    chk("rst_stall_a", 32'(sa), 32'd0);
    chk("rst_flush_a", 32'(fa), 32'd0);
    cyc();
    idle();
    rst = 1'b1;

    // 1: single-cycle load-use bubble (LOAD_LAT=1).
    load_hz();
    #1 chk("lu1_ctrl", 32'(oa), 32'(STALL));
    cyc();
    idle();
    #1 chk("lu1_after", 32'(oa), 32'(DEF));
    chk("lu1_cnt", 32'(sa), 32'd1);

    // 2: near-misses produce no bubble.
    do_reset();
    load_hz(); EX_wR = 5'd0; ID_rR1 = 5'd0;
    #1 chk("nh_wr0", 32'(oa), 32'(DEF));
    cyc();
    load_hz(); ID_rr1 = 1'b0;
    #1 chk("nh_rr1", 32'(oa), 32'(DEF));
    cyc();
    load_hz(); ID_useful = 1'b0;
    #1 chk("nh_idu", 32'(oa), 32'(DEF));
    cyc();
    load_hz(); EX_wbSel = 2'b00;
    #1 chk("nh_alu", 32'(oa), 32'(DEF));
    cyc();
    load_hz(); EX_regWEn = 1'b0;
    #1 chk("nh_nowe", 32'(oa), 32'(DEF));
    cyc();
    chk("nh_cnt", 32'(sa), 32'd0);
    // rR2 path does hazard
    load_hz(); ID_rr1 = 1'b0; ID_rR2 = 5'd5; ID_rr2 = 1'b1;
    #1 chk("lu_rr2", 32'(oa), 32'(STALL));
    cyc();
    idle();
    #1 chk("lu_rr2_cnt", 32'(sa), 32'd1);

    // 3: taken branch with a 3-cycle IF_ID kill; LOAD_LAT-3 instance kills for 1 cycle only.
    do_reset();
    br_taken = 1'b1;
    #1 chk("br_c1_a", 32'(oa), 32'(BR0));
    chk("br_c1_b", 32'(ob), 32'(BR0));
    cyc();
    idle();
    #1 chk("br_c2_a", 32'(oa), 32'(KILL));
    chk("br_c2_b", 32'(ob), 32'(DEF));
    chk("br_fcnt", 32'(fa), 32'd1);
    cyc();
    #1 chk("br_c3_a", 32'(oa), 32'(KILL));
    cyc();
    #1 chk("br_c4_a", 32'(oa), 32'(DEF));
    // Branch beats a same-cycle hazard; memory freeze beats both.
    load_hz(); br_taken = 1'b1; mem_busy = 1'b1;
    #1 chk("busy_over_br", 32'(oa), 32'(BUSY));
    cyc();
    chk("busy_fcnt", 32'(fa), 32'd1);
    mem_busy = 1'b0;
    #1 chk("br_over_lu", 32'(oa), 32'(BR0));
    cyc();
    idle();
    #1 chk("br_lu_cnts", 32'(sa), 32'd0);
    chk("br_lu_fcnt", 32'(fa), 32'd2);

    // 4: LOAD_LAT=3 bubble interrupted by a 4-cycle memory freeze.
    do_reset();
    load_hz();
    #1 chk("mb_c1", 32'(ob), 32'(STALL));
    cyc();
    idle(); mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mb_busy", 32'(ob), 32'(BUSY));
      cyc();
    end
    chk("mb_cnt_frozen", sb, 32'd1);
    mem_busy = 1'b0;
    #1 chk("mb_c2", 32'(ob), 32'(STALL));
    cyc();
    #1 chk("mb_c3", 32'(ob), 32'(STALL));
    cyc();
    #1 chk("mb_done", 32'(ob), 32'(DEF));
    chk("mb_cnt", sb, 32'd3);

    // 5: reset in the middle of a LOAD_LAT=4 bubble.
    do_reset();
    load_hz();
    #1 chk("rs_c1", 32'(oc), 32'(STALL));
    cyc();
    idle();
    #1 chk("rs_c2", 32'(oc), 32'(STALL));
    chk("rs_cnt_pre", 32'(sc), 32'd1);
    rst = 1'b0;
    #1 chk("rs_async", 32'(oc), 32'(DEF));
    cyc();
    rst = 1'b1;
    #1 chk("rs_run", 32'(oc), 32'(DEF));
    chk("rs_cnt", 32'(sc), 32'd0);
    cyc();
    #1 chk("rs_run2", 32'(oc), 32'(DEF));

    // 6: 4-bit stall counter saturates, then clears.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      load_hz();
      cyc();
      idle();
      cyc();
    end
    chk("sat_cnt", 32'(sa), 32'd15);
    load_hz(); cnt_clr = 1'b1;
    cyc();
    idle();
    #1 chk("clr_lost_inc", 32'(sa), 32'd0);
    load_hz();
    cyc();
    idle();
    #1 chk("clr_then_inc", 32'(sa), 32'd1);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    #1 chk("clr", 32'(sa), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
